i2c_pwm_bank: RTL and testbench
===============================

Name: i2c_pwm_bank

Overview:
Parametrised multi-channel PWM/GPIO peripheral. It attaches to the i2c_slave application interface (addr/wen/wdata/rdata) and replaces the single-pin PWM register pair. It drives NCH output pins, each selectable as static level, PWM, or inverted PWM. Duty registers are double-buffered, and a shared programmable prescaler sets the PWM rate.

Parameters:
NCH, 4, number of channels (1..8)
PW, 8, PWM counter/duty width in bits (4..8); duty uses wdata[PW-1:0]
BASE, 8'h04, first register address of the block

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
addr  input  8  register address from i2c_slave
wen  input  1  one-cycle write strobe
wdata  input  8  write data
rdata  output  8  read data, combinational from addr
pwm_out  output  NCH  channel output levels, registered
pwm_oe  output  NCH  channel output enables, registered
period_wrap  output  1  one-cycle pulse when the PWM counter wraps

Behaviour:
- Reset: clk edge with rst=1 clears every register to 0: CTRL, DUTY shadow and active, PRESC, prescale and PWM counters. pwm_out=0, pwm_oe=0, period_wrap=0. Reset overrides a simultaneous wen.
- Register map, per channel i (0..NCH-1):
  - BASE+2i = CTRL[i]: [1:0] mode, [2] static level, [3] oe; bits [7:4] read 0.
  - BASE+2i+1 = DUTY[i] shadow.
- BASE+2*NCH = PRESC (8 bit).
- BASE+2*NCH+1 = STATUS, read-only: {0-padding, cnt[PW-1:0]}. Writes to STATUS are ignored.
- Any other address: reads 8'h00; writes are ignored.
- Register write: takes effect on the clk edge where wen=1. Read data reflects the new value from the next cycle.
- Prescaler: pcnt counts 0..PRESC. tick=1 when pcnt==PRESC, and pcnt then returns to 0. PRESC=0 gives tick every cycle.
- Writing PRESC clears pcnt on the same edge; no tick in that cycle.
- PWM counter: cnt[PW-1:0] increments on tick and wraps from 2^PW-1 to 0.
- wrap = tick && cnt==2^PW-1. period_wrap is registered: it is high for the cycle after the wrap edge.
- Double buffer: on wrap, duty_active[i] <= DUTY[i] for all channels.
- Double-buffer exception: while mode[i]==00, duty_active[i] follows DUTY[i] every cycle.
- DUTY write in the same cycle as wrap: duty_active loads the OLD shadow value. The new value is applied at the next wrap.
- Output, per channel, registered with 1-cycle latency from cnt/CTRL:
  - mode 00: static, pwm_out = CTRL[2].
  - mode 01: PWM, pwm_out = (cnt < duty_active).
  - mode 10: inverted PWM, pwm_out = ~(cnt < duty_active).
  - mode 11: reserved, pwm_out = 0.
- PWM boundaries: duty 0 gives constant low (mode 01). duty 2^PW-1 gives high for 2^PW-1 of 2^PW counts; 100% is achieved with mode 00.
- pwm_oe[i] = CTRL[i][3], registered (1-cycle latency).
- Width: for PW<8, wdata[7:PW] of DUTY writes is discarded and reads back 0.
- Mode change mid-period: applies from the next cycle, with no wait for wrap. cnt is not disturbed.
- Counters run continuously regardless of channel modes.

Test Plan:
- Reset: drive rst=1 with wen=1 writing CTRL0=8'h09. -> all outputs 0; CTRL0 reads 8'h00 after reset.
- PWM basic: NCH=4, PW=8, PRESC=0, DUTY0=64, CTRL0=8'h09. -> pwm_out[0] high 64 of every 256 cycles; pwm_oe[0]=1; period_wrap pulses every 256 cycles.
- Double buffer: in mode 01, write DUTY0=200 in the same cycle as wrap. -> the next period still uses 64, the following period uses 200. STATUS reads cnt.
- Prescaler: PRESC=3, DUTY1=2, CTRL1=8'h01. -> cnt advances every 4 cycles; pwm_out[1] high 8 of every 1024 cycles. Writing PRESC mid-run restarts pcnt at 0.
- Modes: CTRL2=8'h04 -> pwm_out[2]=1 constant. CTRL2=8'h02 with duty 0 -> constant 1. CTRL2=8'h03 -> 0.
- Map edges: a write to STATUS or to BASE+2*NCH+2 changes nothing, and both addresses read as expected (cnt and 8'h00). With PW=4, writing DUTY3=8'hFF reads back 8'h0F.

Source files
------------

// File: rtl/i2c_pwm_bank.sv
// i2c_pwm_bank: multi-channel PWM/GPIO bank behind the i2c_slave register interface.
// Ports: clk/rst (sync, active-high); addr/wen/wdata write path and combinational rdata;
// pwm_out/pwm_oe registered per-channel level and enable; period_wrap pulses after each PWM wrap.
module i2c_pwm_bank #(
  parameter int NCH = 4,
  parameter int PW = 8,
  parameter logic [7:0] BASE = 8'h04
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     addr,
  input  logic           wen,
  input  logic [7:0]     wdata,
  output logic [7:0]     rdata,
  output logic [NCH-1:0] pwm_out,
  output logic [NCH-1:0] pwm_oe,
  output logic           period_wrap
);
  localparam logic [7:0] PRESC_A = 8'(int'(BASE) + 2 * NCH);
  localparam logic [7:0] STATUS_A = 8'(int'(BASE) + 2 * NCH + 1);
  logic [3:0] ctrl [NCH];
  logic [PW-1:0] duty [NCH];
  logic [PW-1:0] duty_act [NCH];
  logic [7:0] presc, pcnt;
  logic [PW-1:0] cnt;
  logic presc_wr, tick, wrap;
  assign presc_wr = wen && addr == PRESC_A;
  // a PRESC write restarts the prescaler, so that edge never ticks
  assign tick = !presc_wr && pcnt == presc;
  assign wrap = tick && &cnt;
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (addr == 8'(int'(BASE) + 2 * i)) rdata = {4'b0, ctrl[i]};
      if (addr == 8'(int'(BASE) + 2 * i + 1)) rdata = 8'(duty[i]);
    end
    if (addr == PRESC_A) rdata = presc;
    if (addr == STATUS_A) rdata = 8'(cnt);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        ctrl[i] <= '0;
        duty[i] <= '0;
        duty_act[i] <= '0;
      end
      presc <= '0;
      pcnt <= '0;
      cnt <= '0;
      pwm_out <= '0;
      pwm_oe <= '0;
      period_wrap <= 1'b0;
    end else begin
      pcnt <= (presc_wr || tick) ? 8'd0 : pcnt + 8'd1;
      if (presc_wr) presc <= wdata;
      if (tick) cnt <= cnt + 1'b1;
      period_wrap <= wrap;
      for (int i = 0; i < NCH; i++) begin
        if (wen && addr == 8'(int'(BASE) + 2 * i)) ctrl[i] <= wdata[3:0];
        if (wen && addr == 8'(int'(BASE) + 2 * i + 1)) duty[i] <= wdata[PW-1:0];
        // active duty takes the pre-write shadow; static mode keeps it tracking
        if (wrap || ctrl[i][1:0] == 2'b00) duty_act[i] <= duty[i];
        pwm_out[i] <= ctrl[i][1:0] == 2'b00 ? ctrl[i][2] :
                      ctrl[i][1:0] == 2'b01 ? (cnt < duty_act[i]) :
                      ctrl[i][1:0] == 2'b10 ? !(cnt < duty_act[i]) : 1'b0;
        pwm_oe[i] <= ctrl[i][3];
      end
    end
  end
endmodule

// File: tb/tb_i2c_pwm_bank.sv
// tb_i2c_pwm_bank: self-checking bench for i2c_pwm_bank (default build plus a PW=4 build).
module tb_i2c_pwm_bank;
  logic clk = 0, rst = 1, wen = 0;
  logic [7:0] addr = 0, wdata = 0, r0, r1;
  logic [3:0] po0, oe0, po1, oe1;
  logic pw0, pw1;
  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];
  typedef struct {logic [7:0] a; logic [7:0] d; logic [7:0] e;} vec_t;
  vec_t tv[8];
  always #5 clk = ~clk;
  i2c_pwm_bank u (.clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata),
    .rdata(r0), .pwm_out(po0), .pwm_oe(oe0), .period_wrap(pw0));
  i2c_pwm_bank #(.NCH(4), .PW(4), .BASE(8'h20)) u4 (.clk(clk), .rst(rst), .addr(addr), .wen(wen),
    .wdata(wdata), .rdata(r1), .pwm_out(po1), .pwm_oe(oe1), .period_wrap(pw1));
  task automatic chk(input string nm, input int got, input int e);
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, e);
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; wen = 1;
    @(posedge clk);
    #1 wen = 0;
  endtask
  task automatic rd(input string nm, input logic [7:0] a, input logic [7:0] e, input bit sel);
    logic [7:0] got, x;
    exp_q.push_back(e);
    addr = a;
    #1 got = sel ? r1 : r0;
    x = exp_q.pop_front();
    chk(nm, got, x);
  endtask
  task automatic wait_wrap(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pw0 && n < lim);
    chk("wrap_wait", pw0, 1);
  endtask
  task automatic count_hi(input int ch, input int n, output int h, output int w);
    h = 0; w = 0;
    repeat (n) begin
      @(negedge clk);
      h += po0[ch];
      w += pw0;
    end
  endtask
  initial begin
    int h, w;
    tv[0] = '{8'h04, 8'hF0, 8'h00};
    tv[1] = '{8'h05, 8'hAB, 8'hAB};
    tv[2] = '{8'h07, 8'h5A, 8'h5A};
    tv[3] = '{8'h0E, 8'h77, 8'h00};
    tv[4] = '{8'h03, 8'h12, 8'h00};
    tv[5] = '{8'h04, 8'h0D, 8'h0D};
    tv[6] = '{8'h0C, 8'h00, 8'h00};
    tv[7] = '{8'h27, 8'hFF, 8'h0F};
    addr = 8'h04; wdata = 8'h09; wen = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pwm_out", po0, 0);
    chk("rst_pwm_oe", oe0, 0);
    chk("rst_wrap", pw0, 0);
    rst = 0; wen = 0;
    rd("rst_ctrl0", 8'h04, 8'h00, 0);
    for (int i = 0; i < 8; i++) begin
      wr(tv[i].a, tv[i].d);
      rd($sformatf("vec%0d", i), tv[i].a, tv[i].e, i == 7);
    end
    wr(8'h0D, 8'h55);
    rd("status_wr_presc", 8'h0C, 8'h00, 0);
    rd("status_wr_ctrl0", 8'h04, 8'h0D, 0);
    wr(8'h04, 8'h00);
    wr(8'h05, 8'd64);
    wr(8'h04, 8'h09);
    wait_wrap(600);
    count_hi(0, 256, h, w);
    chk("pwm0_high", h, 64);
    chk("pwm0_wraps", w, 1);
    chk("pwm0_oe", oe0[0], 1);
    wait_wrap(600);
    rd("status_cnt0", 8'h0D, 8'h00, 0);
    repeat (9) @(negedge clk);
    rd("status_cnt9", 8'h0D, 8'h09, 0);
    repeat (245) @(negedge clk);
    wr(8'h05, 8'd200);
    count_hi(0, 256, h, w);
    chk("dbuf_old", h, 64);
    chk("dbuf_old_wraps", w, 1);
    count_hi(0, 256, h, w);
    chk("dbuf_new", h, 200);
    wr(8'h0C, 8'd3);
    wr(8'h07, 8'd2);
    wr(8'h06, 8'h01);
    wait_wrap(2100);
    count_hi(1, 1024, h, w);
    chk("presc_pwm1_high", h, 8);
    chk("presc_wraps", w, 1);
    wait_wrap(2100);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      rd($sformatf("presc_cnt_k%0d", k), 8'h0D, 8'(k / 4), 0);
    end
    addr = 8'h0C; wdata = 8'd3; wen = 1;
    @(posedge clk);
    #1 wen = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      rd($sformatf("presc_restart_j%0d", j), 8'h0D, j < 4 ? 8'd2 : 8'd3, 0);
    end
    wr(8'h08, 8'h04);
    repeat (2) @(negedge clk);
    count_hi(2, 64, h, w);
    chk("mode_static1", h, 64);
    wr(8'h08, 8'h02);
    repeat (2) @(negedge clk);
    count_hi(2, 64, h, w);
    chk("mode_inv_duty0", h, 64);
    wr(8'h08, 8'h03);
    repeat (2) @(negedge clk);
    count_hi(2, 64, h, w);
    chk("mode_reserved", h, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
